// File: rtl/trig_lane_scheduler.sv
// -----------------------------------------------------------------------------
// trig_lane_scheduler
//
// Shares the 4-lane LVDS trigger output path among N_REQ trigger-candidate
// sources. A round-robin arbiter picks one candidate at a time. Its
// band/phi ID word goes out MSB first on the d1 lane and its BCID word on the
// d0 lane, as even/odd bit pairs, one pair per clk_320M cycle. The enable
// lane flags which cycles carry data. Every lane output comes straight from
// a flop, so this block can drive the DDR output stage directly.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   FRAME_W  bits per lane per frame (even, 4..32)
//   MIN_GAP  enable-low cycles forced between frames (0..15)
//
// Ports
//   clk_320M                 serializer clock, shared with the DDR stage
//   rst                      asynchronous active-high reset
//   sched_en                 when low, no new grants are issued
//   req_valid[N_REQ]         per-requester candidate valid
//   req_ready[N_REQ]         one-hot combinational grant
//   req_band_phi_id          packed words, requester i at [i*FRAME_W +: FRAME_W]
//   req_bcid                 packed words, same layout
//   en_flag_even/_odd        enable lane bits (even is sent first)
//   band_phi_id_even/_odd    d1 lane bits
//   bcid_extend_even/_odd    d0 lane bits
//   busy                     high whenever the FSM is not in IDLE
//   frame_cnt[16]            number of frames started, wraps at 0xFFFF
//
// Build option
//   TRIG_LANE_PARITY_EN  when defined, an extra cycle follows the last data
//                        pair. That cycle sends en=(1,0) and puts the XOR of
//                        each word on the even bit of its lane.
// -----------------------------------------------------------------------------
module trig_lane_scheduler #(
  parameter int N_REQ   = 4,
  parameter int FRAME_W = 16,
  parameter int MIN_GAP = 1
) (
  input  logic                       clk_320M,
  input  logic                       rst,
  input  logic                       sched_en,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*FRAME_W-1:0]   req_band_phi_id,
  input  logic [N_REQ*FRAME_W-1:0]   req_bcid,
  output logic                       en_flag_even,
  output logic                       en_flag_odd,
  output logic                       band_phi_id_even,
  output logic                       band_phi_id_odd,
  output logic                       bcid_extend_even,
  output logic                       bcid_extend_odd,
  output logic                       busy,
  output logic [15:0]                frame_cnt
);

  localparam int PAIRS = FRAME_W / 2;
  localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int PTR_W = $clog2(N_REQ);

  localparam logic [CNT_W-1:0] PAIR_LOAD = CNT_W'(PAIRS - 1);
  localparam logic [3:0]       GAP_LOAD  = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W:0]   N_REQ_EXT = (PTR_W + 1)'(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_GAP
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [FRAME_W-1:0] sh_bpi_q, sh_bpi_d;
  logic [FRAME_W-1:0] sh_bcid_q, sh_bcid_d;
  logic [CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic en_even_q, en_even_d;
  logic en_odd_q, en_odd_d;
  logic bpi_even_q, bpi_even_d;
  logic bpi_odd_q, bpi_odd_d;
  logic bcid_even_q, bcid_even_d;
  logic bcid_odd_q, bcid_odd_d;

`ifdef TRIG_LANE_PARITY_EN
  logic par_bpi_q, par_bpi_d;
  logic par_bcid_q, par_bcid_d;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first valid requester at or after ptr_q, wrapping.
  // ---------------------------------------------------------------------------
  logic [PTR_W:0]     cand_ext;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   grant_idx;
  logic               found;
  logic [N_REQ-1:0]   grant_oh;
  logic               can_grant;
  logic               accept;
  logic [FRAME_W-1:0] sel_bpi;
  logic [FRAME_W-1:0] sel_bcid;

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand_ext  = '0;
    cand      = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_ext = {1'b0, ptr_q} + (PTR_W + 1)'(k);
      if (cand_ext >= N_REQ_EXT) begin
        cand_ext = cand_ext - N_REQ_EXT;
      end
      cand = cand_ext[PTR_W-1:0];
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_oh = found ? (N_REQ'(1) << grant_idx) : '0;
  end

  // The grant is gated by rst as well, so req_ready also drops to zero
  // during reset.
  assign can_grant = (state_q == ST_IDLE) && sched_en && !rst;
  assign req_ready = can_grant ? grant_oh : '0;
  assign accept    = |(req_valid & req_ready);

  // Word mux for the granted requester.
  always_comb begin
    sel_bpi  = '0;
    sel_bcid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_bpi  = req_band_phi_id[i*FRAME_W +: FRAME_W];
        sel_bcid = req_bcid[i*FRAME_W +: FRAME_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk_320M or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // pair_cnt_q counts the pairs still to load after the one now on the
        // lanes. Zero means this is the last data cycle of the frame.
        if (pair_cnt_q == '0) begin
`ifdef TRIG_LANE_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
`endif
        end
      end
      ST_PARITY: begin
        state_d = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next values.
  // The lane flops load the pair that must appear in the following cycle. The
  // accept edge loads the first pair straight from the granted word, so data
  // appears at T+1. The shift registers hold the remaining bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    en_even_d   = 1'b0;
    en_odd_d    = 1'b0;
    bpi_even_d  = 1'b0;
    bpi_odd_d   = 1'b0;
    bcid_even_d = 1'b0;
    bcid_odd_d  = 1'b0;
    sh_bpi_d    = sh_bpi_q;
    sh_bcid_d   = sh_bcid_q;
    pair_cnt_d  = pair_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ptr_d       = ptr_q;
    frame_cnt_d = frame_cnt_q;
`ifdef TRIG_LANE_PARITY_EN
    par_bpi_d   = par_bpi_q;
    par_bcid_d  = par_bcid_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          en_even_d   = 1'b1;
          en_odd_d    = 1'b1;
          bpi_even_d  = sel_bpi[FRAME_W-1];
          bpi_odd_d   = sel_bpi[FRAME_W-2];
          bcid_even_d = sel_bcid[FRAME_W-1];
          bcid_odd_d  = sel_bcid[FRAME_W-2];
          sh_bpi_d    = sel_bpi << 2;
          sh_bcid_d   = sel_bcid << 2;
          pair_cnt_d  = PAIR_LOAD;
          ptr_d       = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
          frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef TRIG_LANE_PARITY_EN
          par_bpi_d   = ^sel_bpi;
          par_bcid_d  = ^sel_bcid;
`endif
        end
      end

      ST_SHIFT: begin
        if (pair_cnt_q != '0) begin
          en_even_d   = 1'b1;
          en_odd_d    = 1'b1;
          bpi_even_d  = sh_bpi_q[FRAME_W-1];
          bpi_odd_d   = sh_bpi_q[FRAME_W-2];
          bcid_even_d = sh_bcid_q[FRAME_W-1];
          bcid_odd_d  = sh_bcid_q[FRAME_W-2];
          sh_bpi_d    = sh_bpi_q << 2;
          sh_bcid_d   = sh_bcid_q << 2;
          pair_cnt_d  = pair_cnt_q - CNT_W'(1);
        end else begin
`ifdef TRIG_LANE_PARITY_EN
          // Parity cycle: enable is (1,0), parity bits go on the even lanes.
          en_even_d   = 1'b1;
          bpi_even_d  = par_bpi_q;
          bcid_even_d = par_bcid_q;
`else
          gap_cnt_d   = GAP_LOAD;
`endif
        end
      end

      ST_PARITY: begin
        gap_cnt_d = GAP_LOAD;
      end

      ST_GAP: begin
        if (gap_cnt_q != 4'd0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and lane registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_320M or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      sh_bpi_q    <= '0;
      sh_bcid_q   <= '0;
      pair_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      en_even_q   <= 1'b0;
      en_odd_q    <= 1'b0;
      bpi_even_q  <= 1'b0;
      bpi_odd_q   <= 1'b0;
      bcid_even_q <= 1'b0;
      bcid_odd_q  <= 1'b0;
`ifdef TRIG_LANE_PARITY_EN
      par_bpi_q   <= 1'b0;
      par_bcid_q  <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      sh_bpi_q    <= sh_bpi_d;
      sh_bcid_q   <= sh_bcid_d;
      pair_cnt_q  <= pair_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      en_even_q   <= en_even_d;
      en_odd_q    <= en_odd_d;
      bpi_even_q  <= bpi_even_d;
      bpi_odd_q   <= bpi_odd_d;
      bcid_even_q <= bcid_even_d;
      bcid_odd_q  <= bcid_odd_d;
`ifdef TRIG_LANE_PARITY_EN
      par_bpi_q   <= par_bpi_d;
      par_bcid_q  <= par_bcid_d;
`endif
    end
  end

  assign en_flag_even     = en_even_q;
  assign en_flag_odd      = en_odd_q;
  assign band_phi_id_even = bpi_even_q;
  assign band_phi_id_odd  = bpi_odd_q;
  assign bcid_extend_even = bcid_even_q;
  assign bcid_extend_odd  = bcid_odd_q;
  assign busy             = (state_q != ST_IDLE);
  assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_trig_lane_scheduler.sv
// -----------------------------------------------------------------------------
// tb_trig_lane_scheduler
//
// Directed bench for trig_lane_scheduler. It uses two instances:
//   dut    default configuration (N_REQ=4, FRAME_W=16, MIN_GAP=1)
//   dut_s  small configuration   (N_REQ=2, FRAME_W=4,  MIN_GAP=0)
// When TRIG_LANE_PARITY_EN is defined, the expected frame length and the
// parity-cycle values follow that build.
// -----------------------------------------------------------------------------
module tb_trig_lane_scheduler;

`ifdef TRIG_LANE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int PERIOD   = 16 / 2 + PAR + 1 + 1;  // accept-to-accept, main DUT
  localparam int S_PERIOD = 4 / 2 + PAR + 1;       // small DUT, MIN_GAP=0

  logic        clk = 1'b0;
  logic        rst;
  logic        sched_en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_bpi;
  logic [63:0] req_bcid;
  logic        en_e, en_o, bpi_e, bpi_o, bcid_e, bcid_o, busy;
  logic [15:0] frame_cnt;

  logic        s_en;
  logic [1:0]  s_valid;
  logic [1:0]  s_ready;
  logic [7:0]  s_bpi;
  logic [7:0]  s_bcid;
  logic        s_en_e, s_en_o, s_bpi_e, s_bpi_o, s_bcid_e, s_bcid_o, s_busy;
  logic [15:0] s_frame_cnt;

  logic [5:0] lanes;
  logic [5:0] s_lanes;
  assign lanes   = {en_e, en_o, bpi_e, bpi_o, bcid_e, bcid_o};
  assign s_lanes = {s_en_e, s_en_o, s_bpi_e, s_bpi_o, s_bcid_e, s_bcid_o};

  trig_lane_scheduler #(.N_REQ(4), .FRAME_W(16), .MIN_GAP(1)) dut (
    .clk_320M         (clk),
    .rst              (rst),
    .sched_en         (sched_en),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_band_phi_id  (req_bpi),
    .req_bcid         (req_bcid),
    .en_flag_even     (en_e),
    .en_flag_odd      (en_o),
    .band_phi_id_even (bpi_e),
    .band_phi_id_odd  (bpi_o),
    .bcid_extend_even (bcid_e),
    .bcid_extend_odd  (bcid_o),
    .busy             (busy),
    .frame_cnt        (frame_cnt)
  );

  trig_lane_scheduler #(.N_REQ(2), .FRAME_W(4), .MIN_GAP(0)) dut_s (
    .clk_320M         (clk),
    .rst              (rst),
    .sched_en         (s_en),
    .req_valid        (s_valid),
    .req_ready        (s_ready),
    .req_band_phi_id  (s_bpi),
    .req_bcid         (s_bcid),
    .en_flag_even     (s_en_e),
    .en_flag_odd      (s_en_o),
    .band_phi_id_even (s_bpi_e),
    .band_phi_id_odd  (s_bpi_o),
    .bcid_extend_even (s_bcid_e),
    .bcid_extend_odd  (s_bcid_o),
    .busy             (s_busy),
    .frame_cnt        (s_frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] d1_tbl;
    logic [15:0] d0_tbl;
    int          exp_g[5];
    int          accepts;
    int          last_cyc;
    int          g;
    int          n;

    rst       = 1'b1;
    sched_en  = 1'b0;
    req_valid = '0;
    req_bpi   = '0;
    req_bcid  = '0;
    s_en      = 1'b0;
    s_valid   = '0;
    s_bpi     = '0;
    s_bcid    = '0;
    repeat (2) tick();

    // ---- reset state (valids present, grant must stay low in reset) ----
    req_valid = 4'hF;
    sched_en  = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_lanes", 32'(lanes), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // ---- single frame: 0xA5C3 / 0x0F0F on requester 0 ----
    d1_tbl = 16'b10_10_01_01_11_00_00_11;
    d0_tbl = 16'b00_00_11_11_00_00_11_11;
    req_bpi[15:0]  = 16'hA5C3;
    req_bcid[15:0] = 16'h0F0F;
    req_valid      = 4'b0001;
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_idle_lanes", 32'(lanes), 32'h0);
    tick();
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1_pair%0d", k), 32'(lanes),
            32'({2'b11, d1_tbl[15-2*k -: 2], d0_tbl[15-2*k -: 2]}));
      if (k == 0) begin
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_frame_cnt", 32'(frame_cnt), 32'h1);
      end
      tick();
    end
`ifdef TRIG_LANE_PARITY_EN
    check("t1_parity", 32'(lanes), 32'(6'b10_00_00));
    tick();
`endif
    check("t1_gap_lanes", 32'(lanes), 32'h0);
    check("t1_gap_busy", 32'(busy), 32'h1);
    check("t1_gap_frame_cnt", 32'(frame_cnt), 32'h1);
    tick();
    check("t1_idle_busy", 32'(busy), 32'h0);

    // ---- round-robin with all four valid, after a fresh reset ----
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    req_bpi  = {16'h0123, 16'hC456, 16'h8789, 16'h4ABC};  // top pairs 00,11,10,01
    req_bcid = {16'hFFFF, 16'h8000, 16'h4000, 16'h0000};  // top pairs 11,10,01,00
    req_valid = 4'hF;
    exp_g    = '{0, 1, 2, 3, 0};
    accepts  = 0;
    last_cyc = 0;
    n        = 0;
    while (accepts < 5 && n < 80) begin
      #1;
      if (req_ready != 4'b0000) begin
        g = exp_g[accepts];
        check($sformatf("rr_grant%0d", accepts), 32'(req_ready), 32'(1) << g);
        if (accepts > 0) begin
          check($sformatf("rr_spacing%0d", accepts), 32'(cyc - last_cyc), 32'(PERIOD));
        end
        last_cyc = cyc;
        accepts++;
        tick();
        n++;
        check($sformatf("rr_first_pair%0d", accepts), 32'(lanes),
              32'({2'b11, req_bpi[g*16+15 -: 2], req_bcid[g*16+15 -: 2]}));
        check($sformatf("rr_frame_cnt%0d", accepts), 32'(frame_cnt), 32'(accepts));
        if (accepts == 5) begin
          req_valid = '0;
        end
      end else begin
        tick();
        n++;
      end
    end
    check("rr_accepts", 32'(accepts), 32'd5);
    req_valid = '0;
    wait_idle("rr_idle");

    // ---- sched_en dropped at T+3 (pointer now at requester 1) ----
    req_valid = 4'b0010;
    #1;
    check("se_ready", 32'(req_ready), 32'h2);
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k == 2) sched_en = 1'b0;
      check($sformatf("se_en%0d", k), 32'(lanes[5:4]), 32'h3);
      tick();
    end
`ifdef TRIG_LANE_PARITY_EN
    tick();
`endif
    check("se_gap_lanes", 32'(lanes), 32'h0);
    check("se_gap_busy", 32'(busy), 32'h1);
    tick();
    check("se_idle_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("se_ready_off%0d", k), 32'(req_ready), 32'h0);
      tick();
    end
    check("se_frame_cnt", 32'(frame_cnt), 32'd6);
    req_valid = '0;
    sched_en  = 1'b1;

    // ---- reset at T+4 of a frame (pointer now at requester 2) ----
    req_valid = 4'b0100;
    #1;
    check("rm_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    repeat (3) tick();
    check("rm_pre_en", 32'(lanes[5:4]), 32'h3);
    #2 rst = 1'b1;
    #1;
    check("rm_lanes", 32'(lanes), 32'h0);
    check("rm_busy", 32'(busy), 32'h0);
    check("rm_frame_cnt", 32'(frame_cnt), 32'h0);
    req_valid = 4'hF;
    #1;
    check("rm_ready_in_rst", 32'(req_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("rm_ready_after", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();

    // ---- small DUT: FRAME_W=4, MIN_GAP=0, requester 1 always valid ----
    s_bpi[7:4]  = 4'hB;  // pairs (1,0)(1,1), parity 1
    s_bcid[7:4] = 4'h6;  // pairs (0,1)(1,0), parity 0
    s_en        = 1'b1;
    s_valid     = 2'b10;
    for (int i = 0; i < 4 * S_PERIOD; i++) begin
      int p;
      p = i % S_PERIOD;
      #1;
      if (p == 0) begin
        check($sformatf("sm_ready%0d", i), 32'(s_ready), 32'h2);
        check($sformatf("sm_en_low%0d", i), 32'(s_lanes), 32'h0);
      end else begin
        check($sformatf("sm_ready_off%0d", i), 32'(s_ready), 32'h0);
        if (p == 1) check($sformatf("sm_pair0_%0d", i), 32'(s_lanes), 32'(6'b11_10_01));
        if (p == 2) check($sformatf("sm_pair1_%0d", i), 32'(s_lanes), 32'(6'b11_11_10));
        if (p == 3) check($sformatf("sm_par_%0d", i), 32'(s_lanes), 32'(6'b10_10_00));
      end
      tick();
    end
    s_valid = '0;
    check("sm_frame_cnt", 32'(s_frame_cnt), 32'd4);

`ifdef TRIG_LANE_PARITY_EN
    // ---- parity of 0x0001 (odd) and 0x0003 (even) ----
    req_bpi[15:0]  = 16'h0001;
    req_bcid[15:0] = 16'h0003;
    req_valid      = 4'b0001;
    #1;
    check("p2_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (8) tick();
    check("p2_parity", 32'(lanes), 32'(6'b10_10_00));
`endif
    wait_idle("end_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
